// File: rtl/tdc_pkg.sv
// Shared definitions for the multichannel TDC core: word type codes,
// elaboration-time width helpers and readout word field offsets.
// Output word layout, MSB to LSB: {type, ch, coarse, fine}.
package tdc_pkg;

  localparam logic TDC_TYPE_TS   = 1'b0;
  localparam logic TDC_TYPE_FREQ = 1'b1;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int tdc_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Channel field width; at least one bit even for a single channel.
  function automatic int tdc_ch_w(input int n_ch);
    return (tdc_clog2(n_ch) < 1) ? 1 : tdc_clog2(n_ch);
  endfunction

  function automatic int tdc_word_w(input int n_ch, input int coarse_w, input int fine_w);
    return 1 + tdc_ch_w(n_ch) + coarse_w + fine_w;
  endfunction

  function automatic int tdc_fine_lsb();
    return 0;
  endfunction

  function automatic int tdc_coarse_lsb(input int fine_w);
    return fine_w;
  endfunction

  function automatic int tdc_ch_lsb(input int coarse_w, input int fine_w);
    return coarse_w + fine_w;
  endfunction

  function automatic int tdc_type_bit(input int n_ch, input int coarse_w, input int fine_w);
    return tdc_ch_w(n_ch) + coarse_w + fine_w;
  endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head word is visible on
// rd_data_o whenever valid_o is high; rd_data_o is zero while empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module tdc_sync_fifo
  import tdc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic [WIDTH-1:0]          push_data_i,
  input  logic                      pop_i,
  output logic [WIDTH-1:0]          rd_data_o,
  output logic                      valid_o,
  output logic                      full_o,
  output logic [tdc_clog2(DEPTH):0] level_o
);

  localparam int AW = tdc_clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  // Qualify requests against the occupancy at the start of the cycle.
  always_comb begin
    push_ok  = push_i && (level_q != (AW+1)'(DEPTH));
    pop_ok   = pop_i && (level_q != '0);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop_ok) level_d = level_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) level_d = level_q - (AW+1)'(1);
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o   = (level_q != '0);
  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign level_o   = level_q;
  assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/tdc_multichannel_core.sv
// Multichannel TDC timestamping core. Each hit input is synchronised,
// rising-edge detected and captured as {coarse counter, fine code} into a
// per-channel pending register; pending words are arbitrated round-robin
// into a shared FWFT FIFO.
// Optional build macro TDC_FREQMODE_EN adds a freq_mode input that turns
// the channels into windowed edge counters.
//
// Readout handshake: dout_valid is high exactly when the FIFO holds a word
// and dout carries that head word; the word is consumed on a rising ckref
// edge where dout_valid and dout_ready are both high. dout_ready may be
// held high while empty, and dout stays stable until consumed.
module tdc_multichannel_core
  import tdc_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int COARSE_W = 16,
  parameter int FINE_W   = 6,
  parameter int DEPTH    = 16,
  parameter int WIN_LOG2 = 10
) (
  input  logic                                         ckref,
  input  logic                                         rst,
  input  logic                                         enable,
  input  logic [N_CH-1:0]                              hit,
  input  logic [N_CH*FINE_W-1:0]                       fine_code,
  input  logic                                         lost_clr,
  output logic [tdc_word_w(N_CH, COARSE_W, FINE_W)-1:0] dout,
  output logic                                         dout_valid,
  input  logic                                         dout_ready,
  output logic [tdc_clog2(DEPTH):0]                    fifo_level,
  output logic [N_CH-1:0]                              lost
`ifdef TDC_FREQMODE_EN
  ,
  input  logic                                         freq_mode
`endif
);

  localparam int CH_W       = tdc_ch_w(N_CH);
  localparam int WORD_W     = tdc_word_w(N_CH, COARSE_W, FINE_W);
  localparam int FINE_LSB   = tdc_fine_lsb();
  localparam int COARSE_LSB = tdc_coarse_lsb(FINE_W);
  localparam int CH_LSB     = tdc_ch_lsb(COARSE_W, FINE_W);
  localparam int TYPE_BIT   = tdc_type_bit(N_CH, COARSE_W, FINE_W);

  if (N_CH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WIN_LOG2 < 1) begin : g_param_check
    $error("tdc_multichannel_core: illegal parameter set");
  end

  // Hit synchronisers and edge detect.
  logic [N_CH-1:0] s1_q, s2_q, s3_q;
  logic [N_CH-1:0] hit_edge;
  logic [N_CH-1:0] cap_ts;

  // Coarse time base.
  logic [COARSE_W-1:0] coarse_q, coarse_d;

  // Per-channel pending words.
  logic [N_CH-1:0]     pend_v_q, pend_v_d;
  logic [N_CH-1:0]     pend_type_q, pend_type_d;
  logic [COARSE_W-1:0] pend_coarse_q [N_CH];
  logic [COARSE_W-1:0] pend_coarse_d [N_CH];
  logic [FINE_W-1:0]   pend_fine_q [N_CH];
  logic [FINE_W-1:0]   pend_fine_d [N_CH];

  // Lost flags and arbiter.
  logic [N_CH-1:0] lost_q, lost_d, lost_set;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            grant_v;
  logic [CH_W-1:0] grant_ch;
  logic [N_CH-1:0] grant_oh;
  logic [WORD_W-1:0] wr_data;
  logic            fifo_full;

  assign hit_edge = s2_q & ~s3_q & {N_CH{enable}};
  assign coarse_d = enable ? coarse_q + COARSE_W'(1) : coarse_q;

`ifdef TDC_FREQMODE_EN
  logic                freq_mode_q;
  logic                freq_restart;
  logic                win_end;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [COARSE_W-1:0] cnt_q [N_CH];
  logic [COARSE_W-1:0] cnt_d [N_CH];
  logic [COARSE_W-1:0] cnt_inc [N_CH];

  assign cap_ts = hit_edge & ~{N_CH{freq_mode}};

  // Window timer and saturating edge counters; a mode change restarts both.
  always_comb begin
    freq_restart = freq_mode ^ freq_mode_q;
    win_end      = freq_mode && enable && !freq_restart && (win_q == '1);
    win_d        = win_q;
    if (freq_restart) win_d = '0;
    else if (freq_mode && enable) win_d = win_q + WIN_LOG2'(1);
    for (int c = 0; c < N_CH; c++) begin
      cnt_inc[c] = (hit_edge[c] && (cnt_q[c] != '1)) ? cnt_q[c] + COARSE_W'(1) : cnt_q[c];
      cnt_d[c]   = (freq_restart || win_end || !freq_mode) ? '0 : cnt_inc[c];
    end
  end

  // Frequency-mode state registers.
  always_ff @(posedge ckref or posedge rst) begin
    if (rst) begin
      freq_mode_q <= 1'b0;
      win_q       <= '0;
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
    end else begin
      freq_mode_q <= freq_mode;
      win_q       <= win_d;
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= cnt_d[c];
    end
  end
`else
  assign cap_ts = hit_edge;
`endif

  // Round-robin search for the first pending channel at or after rr_ptr.
  always_comb begin
    int idx;
    grant_v  = 1'b0;
    grant_ch = '0;
    idx      = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!grant_v && !fifo_full && pend_v_q[idx]) begin
        grant_v  = 1'b1;
        grant_ch = CH_W'(idx);
      end
    end
    for (int c = 0; c < N_CH; c++) grant_oh[c] = grant_v && (grant_ch == CH_W'(c));
    rr_ptr_d = rr_ptr_q;
    if (grant_v) rr_ptr_d = (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + CH_W'(1);
  end

  // Assemble the granted channel's word for the FIFO.
  always_comb begin
    wr_data = '0;
    wr_data[FINE_LSB +: FINE_W]     = pend_fine_q[grant_ch];
    wr_data[COARSE_LSB +: COARSE_W] = pend_coarse_q[grant_ch];
    wr_data[CH_LSB +: CH_W]         = grant_ch;
    wr_data[TYPE_BIT]               = pend_type_q[grant_ch];
  end

  // Pending register update: a grant frees the slot in the same cycle, so
  // an edge coinciding with the grant is kept; otherwise it is lost.
  always_comb begin
    pend_v_d      = pend_v_q;
    pend_type_d   = pend_type_q;
    pend_coarse_d = pend_coarse_q;
    pend_fine_d   = pend_fine_q;
    lost_set      = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant_oh[c]) pend_v_d[c] = 1'b0;
      if (cap_ts[c]) begin
        if (pend_v_q[c] && !grant_oh[c]) begin
          lost_set[c] = 1'b1;
        end else begin
          pend_v_d[c]      = 1'b1;
          pend_type_d[c]   = TDC_TYPE_TS;
          pend_coarse_d[c] = coarse_q;
          pend_fine_d[c]   = fine_code[c*FINE_W +: FINE_W];
        end
      end
`ifdef TDC_FREQMODE_EN
      if (win_end) begin
        if (pend_v_q[c] && !grant_oh[c]) begin
          lost_set[c] = 1'b1;
        end else begin
          pend_v_d[c]      = 1'b1;
          pend_type_d[c]   = TDC_TYPE_FREQ;
          pend_coarse_d[c] = cnt_inc[c];
          pend_fine_d[c]   = '0;
        end
      end
`endif
    end
    lost_d = (lost_clr ? '0 : lost_q) | lost_set;
  end

  // Synchronisers, coarse counter, pending words, lost flags, rr pointer.
  always_ff @(posedge ckref or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      coarse_q    <= '0;
      pend_v_q    <= '0;
      pend_type_q <= '0;
      lost_q      <= '0;
      rr_ptr_q    <= '0;
      for (int c = 0; c < N_CH; c++) begin
        pend_coarse_q[c] <= '0;
        pend_fine_q[c]   <= '0;
      end
    end else begin
      s1_q          <= hit;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      coarse_q      <= coarse_d;
      pend_v_q      <= pend_v_d;
      pend_type_q   <= pend_type_d;
      lost_q        <= lost_d;
      rr_ptr_q      <= rr_ptr_d;
      pend_coarse_q <= pend_coarse_d;
      pend_fine_q   <= pend_fine_d;
    end
  end

  tdc_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (ckref),
    .rst_i       (rst),
    .push_i      (grant_v),
    .push_data_i (wr_data),
    .pop_i       (dout_valid & dout_ready),
    .rd_data_o   (dout),
    .valid_o     (dout_valid),
    .full_o      (fifo_full),
    .level_o     (fifo_level)
  );

  assign lost = lost_q;

endmodule

// File: tb/tb_tdc_multichannel_core.sv
// Directed testbench for tdc_multichannel_core (N_CH=4, COARSE_W=16,
// FINE_W=6, DEPTH=16). Inputs change and outputs are sampled on the
// falling edge of ckref. Expected words are hand-derived from the
// hit timing: a hit driven at a falling edge while coarse reads k is
// captured with coarse k+2.
module tb_tdc_multichannel_core;
  import tdc_pkg::*;

  localparam int N_CH     = 4;
  localparam int COARSE_W = 16;
  localparam int FINE_W   = 6;
  localparam int DEPTH    = 16;
`ifdef TDC_FREQMODE_EN
  localparam int WIN_LOG2 = 4;
`else
  localparam int WIN_LOG2 = 10;
`endif
  localparam int W = 25;

  logic                     ckref = 1'b0;
  logic                     rst = 1'b1;
  logic                     enable = 1'b1;
  logic [N_CH-1:0]          hit = '0;
  logic [N_CH*FINE_W-1:0]   fine_code = '0;
  logic                     lost_clr = 1'b0;
  logic [W-1:0]             dout;
  logic                     dout_valid;
  logic                     dout_ready = 1'b0;
  logic [4:0]               fifo_level;
  logic [N_CH-1:0]          lost;
`ifdef TDC_FREQMODE_EN
  logic                     freq_mode = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];
  int           act_t[$];

  tdc_multichannel_core #(
    .N_CH(N_CH), .COARSE_W(COARSE_W), .FINE_W(FINE_W), .DEPTH(DEPTH), .WIN_LOG2(WIN_LOG2)
  ) dut (
    .ckref(ckref), .rst(rst), .enable(enable), .hit(hit), .fine_code(fine_code),
    .lost_clr(lost_clr), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .fifo_level(fifo_level), .lost(lost)
`ifdef TDC_FREQMODE_EN
    , .freq_mode(freq_mode)
`endif
  );

  // Clock and watchdog.
  always #5 ckref = ~ckref;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk_word(input logic t, input logic [1:0] ch,
                                           input logic [15:0] co, input logic [5:0] fi);
    return {t, ch, co, fi};
  endfunction

  // Driver tasks.
  task automatic do_reset();
    @(negedge ckref);
    rst = 1'b1;
    hit = '0;
    lost_clr = 1'b0;
    dout_ready = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge ckref);
    rst = 1'b0;
  endtask

  task automatic set_fine_all(input logic [5:0] v);
    for (int c = 0; c < N_CH; c++) fine_code[c*FINE_W +: FINE_W] = v;
  endtask

  // Pull up to n words with dout_ready high, noting the cycle of each.
  task automatic collect(input int n, input int budget);
    int cyc;
    cyc = 0;
    act_q.delete();
    act_t.delete();
    dout_ready = 1'b1;
    while (act_q.size() < n && cyc < budget) begin
      if (dout_valid) begin
        act_q.push_back(dout);
        act_t.push_back(cyc);
      end
      if (act_q.size() < n) begin
        @(negedge ckref);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (lost !== 4'b0000) begin errors++; $display("FAIL reset_lost got %b want 0000", lost); end
  endtask

  task automatic test_single_hit();
    do_reset();
    fine_code = '0;
    fine_code[2*FINE_W +: FINE_W] = 6'h15;
    repeat (97) @(negedge ckref);
    hit = 4'b0100;
    @(negedge ckref); hit = '0;
    @(negedge ckref);
    @(negedge ckref);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", dout_valid); end
    @(negedge ckref);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", dout_valid); end
    checks++; if (dout !== mk_word(1'b0, 2'd2, 16'd99, 6'h15)) begin errors++; $display("FAIL single_word got %h want %h", dout, mk_word(1'b0, 2'd2, 16'd99, 6'h15)); end
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL single_level got %0d want 1", fifo_level); end
    dout_ready = 1'b1;
    @(negedge ckref);
    dout_ready = 1'b0;
    checks++; if (dout_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL single_pop valid=%b level=%0d want 0/0", dout_valid, fifo_level); end
  endtask

  task automatic test_all_channels();
    do_reset();
    dout_ready = 1'b1;
    fine_code = {6'd33, 6'd22, 6'd11, 6'd5};
    repeat (3) @(negedge ckref);
    hit = 4'b1111;
    @(negedge ckref); hit = '0;
    exp_q = '{mk_word(1'b0, 2'd0, 16'd5, 6'd5), mk_word(1'b0, 2'd1, 16'd5, 6'd11),
              mk_word(1'b0, 2'd2, 16'd5, 6'd22), mk_word(1'b0, 2'd3, 16'd5, 6'd33)};
    collect(4, 20);
    checks++; if (act_q.size() != 4) begin errors++; $display("FAIL allch_count got %0d want 4", act_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL allch_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (act_t[3] - act_t[0] != 3) begin errors++; $display("FAIL allch_consecutive span got %0d want 3", act_t[3] - act_t[0]); end
  endtask

  task automatic test_lost();
    do_reset();
    dout_ready = 1'b1;
    set_fine_all(6'h0A);
    repeat (2) @(negedge ckref);
    hit = 4'b1110;
    @(negedge ckref); hit = 4'b0001;
    @(negedge ckref); hit = 4'b0000;
    @(negedge ckref); hit = 4'b0001;
    @(negedge ckref); hit = 4'b0000;
    exp_q = '{mk_word(1'b0, 2'd1, 16'd4, 6'h0A), mk_word(1'b0, 2'd2, 16'd4, 6'h0A),
              mk_word(1'b0, 2'd3, 16'd4, 6'h0A), mk_word(1'b0, 2'd0, 16'd5, 6'h0A)};
    collect(4, 20);
    checks++; if (act_q.size() != 4) begin errors++; $display("FAIL lost_count got %0d want 4", act_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL lost_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    repeat (3) @(negedge ckref);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL lost_extra_word valid=%b want 0", dout_valid); end
    checks++; if (lost !== 4'b0001) begin errors++; $display("FAIL lost_flag got %b want 0001", lost); end
    lost_clr = 1'b1;
    @(negedge ckref); lost_clr = 1'b0;
    checks++; if (lost !== 4'b0000) begin errors++; $display("FAIL lost_clear got %b want 0000", lost); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dout_ready = 1'b1;
    set_fine_all(6'h11);
    repeat (2) @(negedge ckref);
    hit = 4'b0011;
    @(negedge ckref); hit = 4'b0000;
    @(negedge ckref); hit = 4'b0010;
    @(negedge ckref); hit = 4'b0000;
    exp_q = '{mk_word(1'b0, 2'd0, 16'd4, 6'h11), mk_word(1'b0, 2'd1, 16'd4, 6'h11),
              mk_word(1'b0, 2'd1, 16'd6, 6'h11)};
    collect(3, 20);
    checks++; if (act_q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", act_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    checks++; if (lost !== 4'b0000) begin errors++; $display("FAIL b2b_lost got %b want 0000", lost); end
  endtask

  task automatic test_fifo_full();
    int t;
    do_reset();
    exp_q.delete();
    repeat (2) @(negedge ckref);
    t = 2;
    for (int i = 0; i < 22; i++) begin
      set_fine_all(6'(i + 1));
      hit = 4'(1 << (i % 4));
      if (i < 20) exp_q.push_back(mk_word(1'b0, 2'(i % 4), 16'(t + 2), 6'(i + 1)));
      @(negedge ckref); hit = '0;
      repeat (3) @(negedge ckref);
      t = t + 4;
    end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level got %0d want 16", fifo_level); end
    checks++; if (lost !== 4'b0011) begin errors++; $display("FAIL full_lost got %b want 0011", lost); end
    collect(20, 60);
    checks++; if (act_q.size() != 20) begin errors++; $display("FAIL full_count got %0d want 20", act_q.size()); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    repeat (3) @(negedge ckref);
    checks++; if (fifo_level !== 5'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL full_drained level=%0d valid=%b want 0/0", fifo_level, dout_valid); end
    checks++; if (lost !== 4'b0011) begin errors++; $display("FAIL full_lost_sticky got %b want 0011", lost); end
  endtask

  task automatic test_mid_reset();
    dout_ready = 1'b0;
    @(negedge ckref); hit = 4'b0100;
    @(negedge ckref); hit = '0;
    repeat (5) @(negedge ckref);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b want 1", dout_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dout_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL midrst_fifo valid=%b level=%0d want 0/0", dout_valid, fifo_level); end
    checks++; if (lost !== 4'b0000) begin errors++; $display("FAIL midrst_lost got %b want 0000", lost); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL midrst_dout got %h want 0", dout); end
    @(negedge ckref); rst = 1'b0;
  endtask

  task automatic test_coarse_wrap();
    do_reset();
    set_fine_all(6'h07);
    repeat (65533) @(negedge ckref);
    hit = 4'b0001;
    @(negedge ckref); hit = 4'b0010;
    @(negedge ckref); hit = 4'b0000;
    exp_q = '{mk_word(1'b0, 2'd0, 16'hFFFF, 6'h07), mk_word(1'b0, 2'd1, 16'h0000, 6'h07)};
    collect(2, 20);
    checks++; if (act_q.size() != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", act_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
  endtask

`ifdef TDC_FREQMODE_EN
  task automatic test_freq_mode();
    do_reset();
    @(negedge ckref); freq_mode = 1'b1;
    @(negedge ckref);
    for (int k = 0; k < 5; k++) begin
      hit = 4'b0010;
      @(negedge ckref); hit = '0;
      @(negedge ckref);
    end
    exp_q = '{mk_word(1'b1, 2'd0, 16'd0, 6'd0), mk_word(1'b1, 2'd1, 16'd5, 6'd0),
              mk_word(1'b1, 2'd2, 16'd0, 6'd0), mk_word(1'b1, 2'd3, 16'd0, 6'd0)};
    collect(4, 40);
    checks++; if (act_q.size() != 4) begin errors++; $display("FAIL freq_count got %0d want 4", act_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL freq_word[%0d] got %h want %h", i, act_q[i], exp_q[i]); end
    end
    freq_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_all_channels();
    test_lost();
    test_back_to_back();
    test_fifo_full();
    test_mid_reset();
    test_coarse_wrap();
`ifdef TDC_FREQMODE_EN
    test_freq_mode();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
